axi_tdd_ng_sequencer: RTL
=========================

Name: axi_tdd_ng_sequencer

Overview:
Frame timing master for the TDD engine. Arms on enable, waits for a start trigger, runs an optional startup delay, then produces a free-running frame counter for a programmed number of frames. Drives tdd_counter, tdd_cstate and tdd_endof_frame to every TDD output channel, so all channels share one timebase and state.

Parameters:
REGISTER_WIDTH, 32, width of counter, startup_delay and frame_length.
BURST_WIDTH, 32, width of burst_count and tdd_frame_count.

Ports:
clk  input  1  clock
resetn  input  1  synchronous active-low reset
tdd_enable  input  1  global enable; low forces IDLE
sync_soft  input  1  one-cycle software start pulse
sync_ext_en  input  1  enables tdd_sync_ext as a trigger source
tdd_sync_ext  input  1  external start level, already synchronous to clk
startup_delay  input  REGISTER_WIDTH  cycles spent in WAITING before the first frame
frame_length  input  REGISTER_WIDTH  cycles per frame
burst_count  input  BURST_WIDTH  frames per burst; 0 = infinite
tdd_counter  output  REGISTER_WIDTH  current delay or frame counter
tdd_cstate  output  axi_tdd_ng_pkg::state_t  IDLE, ARMED, WAITING or RUNNING
tdd_endof_frame  output  1  high during the last cycle of each frame
tdd_endof_burst  output  1  high during the last cycle of the last frame of a burst
tdd_sync_out  output  1  one-cycle pulse when a trigger is accepted
tdd_frame_count  output  BURST_WIDTH  frames completed in the current burst

Behaviour:
- Reset: resetn is synchronous and active-low on clk. Reset values: tdd_cstate=IDLE; tdd_counter=0; tdd_endof_frame, tdd_endof_burst, tdd_sync_out=0; tdd_frame_count=0; edge register=0; shadow registers=0.
- Every output is registered.
- External trigger: edge register samples tdd_sync_ext every cycle. ext_edge = tdd_sync_ext & ~edge_q & sync_ext_en.
- trigger = sync_soft | ext_edge. External trigger latency is 1 cycle longer than sync_soft because of the edge detect.
- IDLE:
  - tdd_enable=1 -> ARMED next cycle.
  - tdd_counter is held at 0.
- ARMED:
  - Waits for trigger. tdd_counter=0.
  - On the cycle trigger is seen: latch startup_delay, frame_length and burst_count into shadow registers; pulse tdd_sync_out in the next cycle; clear tdd_frame_count.
  - Next state is WAITING if startup_delay != 0, otherwise RUNNING.
  - Triggers in any other state are ignored, with no sync_out.
- WAITING:
  - tdd_counter increments from 0.
  - When tdd_counter == shadow_delay-1: next state is RUNNING and tdd_counter becomes 0.
- RUNNING:
  - tdd_counter increments from 0.
  - When tdd_counter == shadow_len-1: tdd_endof_frame=1 in that same cycle, so its register is computed one cycle ahead.
  - Next cycle: tdd_counter=0 and tdd_frame_count increments.
  - shadow_len 0 or 1 gives one-cycle frames: counter stays 0 and endof_frame stays high.
- Burst end:
  - If shadow_burst != 0 and the frame ending is frame number shadow_burst, tdd_endof_burst=1 alongside tdd_endof_frame.
  - Next state is ARMED and tdd_counter=0. tdd_frame_count holds its final value until the next accepted trigger.
  - shadow_burst=0: RUNNING continues indefinitely. tdd_frame_count wraps modulo 2^BURST_WIDTH.
- Config changes: changes to startup_delay, frame_length or burst_count outside ARMED have no effect until the next accepted trigger.
- tdd_enable=0 in any state:
  - Next cycle: IDLE, tdd_counter=0, all pulses 0, tdd_frame_count=0.
  - An in-progress frame is abandoned, with no endof_frame.
- Simultaneous events:
  - tdd_enable falling together with trigger or frame end: disable wins.
  - sync_soft and ext_edge in the same cycle count as one trigger.
- Counter arithmetic: unsigned, REGISTER_WIDTH bits. A counter never exceeds the compare value minus 1, so no overflow.
- Reset mid-operation behaves identically to the reset state.

Test Plan:
- Reset, then tdd_enable=1 -> tdd_cstate=ARMED after 1 cycle; tdd_counter=0; no pulses.
- startup_delay=3, frame_length=5, burst_count=2, sync_soft pulse at T:
  - sync_out high at T+1; WAITING during T+1..T+3 with counter 0,1,2; RUNNING from T+4.
  - endof_frame at T+8 and T+13; endof_burst at T+13; ARMED at T+14; tdd_frame_count=2.
- startup_delay=0, frame_length=1, burst_count=0, trigger -> RUNNING next cycle; endof_frame high every cycle; tdd_frame_count increments every cycle.
- sync_ext_en=1, tdd_sync_ext held high for 10 cycles while ARMED -> exactly one trigger, 2 cycles after the rising edge. With sync_ext_en=0 -> no trigger.
- frame_length=100 during RUNNING; at counter=40 change frame_length to 10 -> endof_frame still at counter 99; new value used only after re-arm.
- tdd_enable dropped at counter=2 of frame_length=8 -> IDLE next cycle; counter 0; no endof_frame. Same result when it coincides with a trigger or with the frame's last cycle.

Source files
------------

// File: rtl/axi_tdd_ng_sequencer.sv
// Frame timing master for the TDD engine: arm, trigger, optional startup delay,
// then a free-running frame counter for a programmed (or infinite) burst.

package axi_tdd_ng_pkg;
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      WAITING = 2'd2,
      RUNNING = 2'd3
   } state_t;
endpackage

module axi_tdd_ng_sequencer #(
   parameter int REGISTER_WIDTH = 32,
   parameter int BURST_WIDTH    = 32
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          tdd_enable,
   input  logic                          sync_soft,
   input  logic                          sync_ext_en,
   input  logic                          tdd_sync_ext,
   input  logic [REGISTER_WIDTH-1:0]     startup_delay,
   input  logic [REGISTER_WIDTH-1:0]     frame_length,
   input  logic [BURST_WIDTH-1:0]        burst_count,
   output logic [REGISTER_WIDTH-1:0]     tdd_counter,
   output axi_tdd_ng_pkg::state_t        tdd_cstate,
   output logic                          tdd_endof_frame,
   output logic                          tdd_endof_burst,
   output logic                          tdd_sync_out,
   output logic [BURST_WIDTH-1:0]        tdd_frame_count
);
   import axi_tdd_ng_pkg::*;

   localparam logic [REGISTER_WIDTH-1:0] ONE_R = REGISTER_WIDTH'(1);
   localparam logic [BURST_WIDTH-1:0]    ONE_B = BURST_WIDTH'(1);

   state_t                      state_q, state_d;
   logic [REGISTER_WIDTH-1:0]   counter_q, counter_d;
   logic [REGISTER_WIDTH-1:0]   delay_q, delay_d;
   logic [REGISTER_WIDTH-1:0]   len_q, len_d;
   logic [REGISTER_WIDTH-1:0]   last_cnt;
   logic [BURST_WIDTH-1:0]      burst_q, burst_d;
   logic [BURST_WIDTH-1:0]      frames_q, frames_d;
   logic                        eof_q, eof_d;
   logic                        eob_q, eob_d;
   logic                        sync_q, sync_d;
   logic                        edge_q;
   logic                        ext_trig_q;
   logic                        ext_edge;
   logic                        trigger;

   // The external edge is registered once more, so it lands a cycle after a soft pulse would.
   assign ext_edge = tdd_sync_ext & ~edge_q & sync_ext_en;
   assign trigger  = sync_soft | ext_trig_q;

   always_comb begin
      state_d   = state_q;
      counter_d = counter_q;
      frames_d  = frames_q;
      delay_d   = delay_q;
      len_d     = len_q;
      burst_d   = burst_q;
      sync_d    = 1'b0;
      eof_d     = 1'b0;
      eob_d     = 1'b0;
      last_cnt  = '0;

      if (!tdd_enable) begin
         state_d   = IDLE;
         counter_d = '0;
         frames_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d   = ARMED;
               counter_d = '0;
            end
            ARMED: begin
               counter_d = '0;
               if (trigger) begin
                  delay_d  = startup_delay;
                  len_d    = frame_length;
                  burst_d  = burst_count;
                  frames_d = '0;
                  sync_d   = 1'b1;
                  state_d  = (startup_delay != '0) ? WAITING : RUNNING;
               end
            end
            WAITING: begin
               if (counter_q == delay_q - ONE_R) begin
                  state_d   = RUNNING;
                  counter_d = '0;
               end else begin
                  counter_d = counter_q + ONE_R;
               end
            end
            RUNNING: begin
               // eof_q/eob_q already mark the last cycle of the frame/burst.
               if (eof_q) begin
                  frames_d  = frames_q + ONE_B;
                  counter_d = '0;
                  if (eob_q) state_d = ARMED;
               end else begin
                  counter_d = counter_q + ONE_R;
               end
            end
            default: begin
               state_d   = IDLE;
               counter_d = '0;
            end
         endcase
      end

      // Frame-end flags are computed from next-cycle values so they are registered in time.
      last_cnt = (len_d <= ONE_R) ? '0 : len_d - ONE_R;
      if (state_d == RUNNING && counter_d == last_cnt) begin
         eof_d = 1'b1;
         eob_d = (burst_d != '0) && (frames_d + ONE_B == burst_d);
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= IDLE;
         counter_q  <= '0;
         frames_q   <= '0;
         delay_q    <= '0;
         len_q      <= '0;
         burst_q    <= '0;
         eof_q      <= 1'b0;
         eob_q      <= 1'b0;
         sync_q     <= 1'b0;
         edge_q     <= 1'b0;
         ext_trig_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         counter_q  <= counter_d;
         frames_q   <= frames_d;
         delay_q    <= delay_d;
         len_q      <= len_d;
         burst_q    <= burst_d;
         eof_q      <= eof_d;
         eob_q      <= eob_d;
         sync_q     <= sync_d;
         edge_q     <= tdd_sync_ext;
         ext_trig_q <= ext_edge;
      end
   end

   assign tdd_counter     = counter_q;
   assign tdd_cstate      = state_q;
   assign tdd_endof_frame = eof_q;
   assign tdd_endof_burst = eob_q;
   assign tdd_sync_out    = sync_q;
   assign tdd_frame_count = frames_q;

endmodule
